// File: rtl/up_mac_seq_if.sv
// up_* register bus: one-cycle request pulses from the bus master, registered acks/read data back.
// The master owns requests and addresses; the slave owns acks and read data.
interface up_mac_seq_if;
  logic        up_wreq;
  logic [7:0]  up_waddr;
  logic [31:0] up_wdata;
  logic        up_wack;
  logic        up_rreq;
  logic [7:0]  up_raddr;
  logic [31:0] up_rdata;
  logic        up_rack;

  modport master (
    output up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
    input  up_wack, up_rdata, up_rack
  );

  modport slave (
    input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
    output up_wack, up_rdata, up_rack
  );
endinterface

// File: rtl/up_mac_seq.sv
// Sequential signed MAC over CHANNELS operand pairs with wrap/saturate accumulate, behind the up_* bus.
// Bus acks one cycle after request, never stalled; a run takes CHANNELS+1 busy cycles, irq follows.
module up_mac_seq #(
  parameter int ID         = 0,
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  up_mac_seq_if.slave up,
  output logic        busy,
  output logic        irq
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IW-1:0] LAST = IW'(CHANNELS - 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] op_a [CHANNELS];
  logic signed [DATA_WIDTH-1:0] op_b [CHANNELS];
  logic signed [DATA_WIDTH-1:0] cur_a, cur_b;
  logic signed [PW-1:0]         prod_reg;
  logic signed [ACC_WIDTH-1:0]  acc, acc_nxt;
  logic signed [ACC_WIDTH:0]    sum;
  logic signed [63:0]           acc_ext;
  logic [IW-1:0]                idx;
  logic [31:0]                  acc_hi;
  logic [31:0]                  rd_val;
  logic valid, sat_en, done, overflow, sum_ovf;
  logic idle, wr_ctrl, start_req, clear_req, op_wr, op_rd, soft_rst, rd_acc_lo;

  // ---------------------------------------------------------------- decode
  assign idle      = (state == IDLE);
  assign busy      = !idle;
  assign wr_ctrl   = up.up_wreq && (up.up_waddr == 8'h03);
  assign start_req = wr_ctrl && up.up_wdata[0] && idle;
  assign clear_req = wr_ctrl && up.up_wdata[1] && idle;
  assign op_wr     = up.up_wreq && (up.up_waddr[7:6] == 2'b01) && idle;
  assign soft_rst  = up.up_wreq && (up.up_waddr == 8'h20) && !up.up_wdata[0];
  assign op_rd     = (up.up_raddr[7:6] == 2'b01);
  assign rd_acc_lo = up.up_rreq && (up.up_raddr == 8'h05);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_req) state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (soft_rst) state_nxt = IDLE;
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    cur_a = op_a[0];
    cur_b = op_b[0];
    for (int c = 0; c < CHANNELS; c++) begin
      if (idx == IW'(c)) begin
        cur_a = op_a[c];
        cur_b = op_b[c];
      end
    end
  end

  // One guard bit above the accumulator exposes signed overflow as a sign mismatch.
  assign sum     = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(prod_reg);
  assign sum_ovf = (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]);
  assign acc_ext = 64'(acc);

  always_comb begin
    acc_nxt = sum[ACC_WIDTH-1:0];
    if (sum_ovf && sat_en) acc_nxt = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int c = 0; c < CHANNELS; c++) begin
        op_a[c] <= '0;
        op_b[c] <= '0;
      end
      acc      <= '0;
      acc_hi   <= '0;
      prod_reg <= '0;
      idx      <= '0;
      valid    <= 1'b0;
      sat_en   <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else if (soft_rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        op_a[c] <= '0;
        op_b[c] <= '0;
      end
      acc      <= '0;
      acc_hi   <= '0;
      prod_reg <= '0;
      idx      <= '0;
      valid    <= 1'b0;
      sat_en   <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr_ctrl) sat_en <= up.up_wdata[2];
      for (int c = 0; c < CHANNELS; c++) begin
        if (op_wr && (up.up_waddr[5:0] == 6'(c))) begin
          op_a[c] <= up.up_wdata[16 +: DATA_WIDTH];
          op_b[c] <= up.up_wdata[0 +: DATA_WIDTH];
        end
      end
      if (rd_acc_lo) acc_hi <= acc_ext[63:32];

      valid <= (state == RUN);
      irq   <= (state == DRAIN);
      if (state == RUN) begin
        prod_reg <= PW'(cur_a) * PW'(cur_b);
        idx      <= idx + 1'b1;
      end
      if (start_req) begin
        idx  <= '0;
        done <= 1'b0;
      end
      if (state == DRAIN) done <= 1'b1;

      // CLEAR is only accepted when idle, where valid is already low.
      if (clear_req) begin
        acc      <= '0;
        overflow <= 1'b0;
      end else if (valid) begin
        acc <= acc_nxt;
        if (sum_ovf) overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- read mux and bus acks
  always_comb begin
    rd_val = '0;
    case (up.up_raddr)
      8'h00:   rd_val = 32'h0001_0000;
      8'h01:   rd_val = 32'(ID);
      8'h02:   rd_val = 32'h4343_414D;
      8'h03:   rd_val = {29'b0, sat_en, 2'b0};
      8'h04:   rd_val = {16'b0, 8'(CHANNELS), 5'b0, overflow, done, busy};
      8'h05:   rd_val = acc_ext[31:0];
      8'h06:   rd_val = acc_hi;
      default: begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (op_rd && (up.up_raddr[5:0] == 6'(c)))
            rd_val = {16'(op_a[c]), 16'(op_b[c])};
        end
      end
    endcase
  end

  // Not affected by SOFT_RESET so the reset write itself is still acknowledged.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      up.up_wack  <= 1'b0;
      up.up_rack  <= 1'b0;
      up.up_rdata <= '0;
    end else begin
      up.up_wack  <= up.up_wreq;
      up.up_rack  <= up.up_rreq;
      up.up_rdata <= up.up_rreq ? rd_val : 32'h0;
    end
  end

endmodule
